// File: rtl/field_set_ctrl_57_if.sv
// Key, carry and set-mode inputs plus value/status outputs of one settable counter field.
interface field_set_ctrl_57_if #(
  parameter int WIDTH = 3
);
  logic             set_e_57;
  logic             key_add_57;
  logic             key_sub_57;
  logic             carry_i_57;
  logic [WIDTH-1:0] value_o_57;
  logic             carry_o_57;
  logic             rep_act_o_57;

  modport master (
    output set_e_57, key_add_57, key_sub_57, carry_i_57,
    input  value_o_57, carry_o_57, rep_act_o_57
  );

  modport slave (
    input  set_e_57, key_add_57, key_sub_57, carry_i_57,
    output value_o_57, carry_o_57, rep_act_o_57
  );
endinterface

// File: rtl/field_set_ctrl_57.sv
// Settable wrap counter for one calendar field: key steps with auto-repeat in set mode, carry chaining in run mode.
// Value and carry_o are registered one cycle after the step condition; no backpressure.
module field_set_ctrl_57 #(
  parameter int WIDTH    = 3,
  parameter int MIN_VAL  = 1,
  parameter int MAX_VAL  = 7,
  parameter int RST_VAL  = 1,
  parameter int HOLD_CYC = 25_000_000,
  parameter int REP_CYC  = 5_000_000
) (
  input logic                clk_50m_57,
  input logic                rst_n_57,
  field_set_ctrl_57_if.slave fld
);
  localparam int TMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0]    REP_LAST  = TW'(REP_CYC - 1);
  localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V     = WIDTH'(RST_VAL);
  localparam logic [31:0]      MIN_W     = 32'(MIN_VAL);
  localparam logic [31:0]      MAX_W     = 32'(MAX_VAL);

  typedef enum logic [2:0] {IDLE, HOLD_ADD, HOLD_SUB, REP_ADD, REP_SUB} state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic             add_q, sub_q, armed, armed_nx;
  logic             add, sub, both, add_edge, sub_edge, key_held;
  logic             step_up, step_dn, carry_up, in_range;
  logic [WIDTH-1:0] value, value_nx;
  logic [31:0]      value_w;
  logic             carry, carry_nx;

  assign add      = fld.key_add_57;
  assign sub      = fld.key_sub_57;
  assign both     = add & sub;
  // Edges only count once both keys have been seen low; this blocks a key still held across reset or a two-key chord.
  assign armed_nx = both ? 1'b0 : ((~add & ~sub) ? 1'b1 : armed);
  assign add_edge = armed & add & ~add_q;
  assign sub_edge = armed & sub & ~sub_q;
  assign key_held = (state == HOLD_ADD || state == REP_ADD) ? add : sub;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    if (!fld.set_e_57 || both) begin
      state_nx = IDLE;
      timer_nx = '0;
    end else begin
      unique case (state)
        IDLE: begin
          timer_nx = '0;
          if (add_edge) begin
            step_up  = 1'b1;
            state_nx = HOLD_ADD;
          end else if (sub_edge) begin
            step_dn  = 1'b1;
            state_nx = HOLD_SUB;
          end
        end
        HOLD_ADD, HOLD_SUB: begin
          if (!key_held) begin
            state_nx = IDLE;
            timer_nx = '0;
          end else if (timer == HOLD_LAST) begin
            step_up  = (state == HOLD_ADD);
            step_dn  = (state == HOLD_SUB);
            state_nx = (state == HOLD_ADD) ? REP_ADD : REP_SUB;
            timer_nx = '0;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        REP_ADD, REP_SUB: begin
          if (!key_held) begin
            state_nx = IDLE;
            timer_nx = '0;
          end else if (timer == REP_LAST) begin
            step_up  = (state == REP_ADD);
            step_dn  = (state == REP_SUB);
            timer_nx = '0;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          timer_nx = '0;
        end
      endcase
    end
  end

  assign carry_up = ~fld.set_e_57 & fld.carry_i_57;
  assign value_w  = 32'(value);
  assign in_range = (value_w >= MIN_W) && (value_w <= MAX_W);

  // A corrupted value recovers to MIN_VAL on the next step or carry.
  always_comb begin
    value_nx = value;
    carry_nx = 1'b0;
    if (step_up || carry_up) begin
      value_nx = (!in_range || value == MAX_V) ? MIN_V : value + 1'b1;
      carry_nx = carry_up & (value == MAX_V);
    end else if (step_dn) begin
      value_nx = !in_range ? MIN_V : ((value == MIN_V) ? MAX_V : value - 1'b1);
    end
  end

  always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
    if (!rst_n_57) begin
      state <= IDLE;
      timer <= '0;
      add_q <= 1'b0;
      sub_q <= 1'b0;
      armed <= 1'b0;
      value <= RST_V;
      carry <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      add_q <= add;
      sub_q <= sub;
      armed <= armed_nx;
      value <= value_nx;
      carry <= carry_nx;
    end
  end

  assign fld.value_o_57   = value;
  assign fld.carry_o_57   = carry;
  assign fld.rep_act_o_57 = (state == REP_ADD) || (state == REP_SUB);
endmodule

// File: tb/tb_field_set_ctrl_57.sv
// Bench for field_set_ctrl_57: a weekday instance and a month instance checked every cycle against a press-age model.
module tb_field_set_ctrl_57;
  localparam int HOLD = 4;
  localparam int REP  = 2;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  field_set_ctrl_57_if #(.WIDTH(3)) bus ();
  field_set_ctrl_57_if #(.WIDTH(4)) mbus ();

  field_set_ctrl_57 #(.WIDTH(3), .MIN_VAL(1), .MAX_VAL(7), .RST_VAL(1),
                      .HOLD_CYC(HOLD), .REP_CYC(REP)) dut (
    .clk_50m_57(clk), .rst_n_57(rst_n), .fld(bus.slave));

  field_set_ctrl_57 #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .RST_VAL(1),
                      .HOLD_CYC(HOLD), .REP_CYC(REP)) dut_m (
    .clk_50m_57(clk), .rst_n_57(rst_n), .fld(mbus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: press = 0 none, 1 add, 2 sub; age = cycles since the accepted press edge.
  typedef struct packed {
    int value;
    bit carry;
    bit rep;
    int press;
    int age;
    bit armed;
    bit padd;
    bit psub;
  } mst_t;

  mst_t ma, mm;

  function automatic mst_t mreset(int rv);
    mst_t n;
    n = '0;
    n.value = rv;
    return n;
  endfunction

  function automatic mst_t mstep(mst_t s, bit se, bit ka, bit ks, bit ci, int mn, int mx);
    mst_t n;
    bit up, dn, held;
    n = s;
    up = 1'b0;
    dn = 1'b0;
    n.carry = 1'b0;
    if (!se) begin
      n.press = 0;
      n.age = 0;
    end else if (ka && ks) begin
      n.press = 0;
      n.age = 0;
    end else if (s.press != 0) begin
      held = (s.press == 1) ? ka : ks;
      if (!held) begin
        n.press = 0;
        n.age = 0;
      end else begin
        n.age = s.age + 1;
        if (n.age >= HOLD && ((n.age - HOLD) % REP) == 0) begin
          up = (s.press == 1);
          dn = (s.press == 2);
        end
      end
    end else if (s.armed && ka && !s.padd) begin
      n.press = 1;
      n.age = 0;
      up = 1'b1;
    end else if (s.armed && ks && !s.psub) begin
      n.press = 2;
      n.age = 0;
      dn = 1'b1;
    end
    if (!se && ci) begin
      up = 1'b1;
      n.carry = (s.value == mx);
    end
    if (up) n.value = (s.value == mx) ? mn : s.value + 1;
    else if (dn) n.value = (s.value == mn) ? mx : s.value - 1;
    n.rep = (n.press != 0) && (n.age >= HOLD);
    if (ka && ks) n.armed = 1'b0;
    else if (!ka && !ks) n.armed = 1'b1;
    n.padd = ka;
    n.psub = ks;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = mreset(1);
      mm = mreset(1);
    end else begin
      ma = mstep(ma, bus.set_e_57, bus.key_add_57, bus.key_sub_57, bus.carry_i_57, 1, 7);
      mm = mstep(mm, mbus.set_e_57, mbus.key_add_57, mbus.key_sub_57, mbus.carry_i_57, 1, 12);
    end
  end

  task automatic check(string name, logic [31:0] act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("value", 32'(bus.value_o_57), ma.value);
    check("carry", 32'(bus.carry_o_57), int'(ma.carry));
    check("rep_act", 32'(bus.rep_act_o_57), int'(ma.rep));
    check("m_value", 32'(mbus.value_o_57), mm.value);
    check("m_carry", 32'(mbus.carry_o_57), int'(mm.carry));
    check("m_rep_act", 32'(mbus.rep_act_o_57), int'(mm.rep));
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(bit a, bit s);
    bus.key_add_57 = a;
    bus.key_sub_57 = s;
    tick(1);
    bus.key_add_57 = 1'b0;
    bus.key_sub_57 = 1'b0;
    tick(1);
  endtask

  int cnt;
  int last;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.set_e_57 = 1'b0;  bus.key_add_57 = 1'b0;  bus.key_sub_57 = 1'b0;  bus.carry_i_57 = 1'b0;
    mbus.set_e_57 = 1'b0; mbus.key_add_57 = 1'b0; mbus.key_sub_57 = 1'b0; mbus.carry_i_57 = 1'b0;
    tick(3);
    check("rst_value", 32'(bus.value_o_57), 1);
    check("rst_rep", 32'(bus.rep_act_o_57), 0);
    rst_n = 1'b1;
    bus.set_e_57 = 1'b1;
    tick(2);

    press(1, 0);
    check("add_1_to_2", 32'(bus.value_o_57), 2);
    press(0, 1);
    press(0, 1);
    check("sub_wrap_1_to_7", 32'(bus.value_o_57), 7);
    press(1, 0);
    check("add_wrap_7_to_1", 32'(bus.value_o_57), 1);

    bus.key_add_57 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 1) check("hold_first_step", 32'(bus.value_o_57), 2);
      if (k == 4) check("hold_rep_not_yet", 32'(bus.rep_act_o_57), 0);
      if (k == 5) begin
        check("hold_second_step", 32'(bus.value_o_57), 3);
        check("rep_act_on", 32'(bus.rep_act_o_57), 1);
      end
      if (k == 12) check("hold_last_value", 32'(bus.value_o_57), 6);
    end
    bus.key_add_57 = 1'b0;
    tick(1);
    check("release_rep_off", 32'(bus.rep_act_o_57), 0);

    tick(1);
    bus.key_add_57 = 1'b1;
    bus.key_sub_57 = 1'b1;
    tick(2);
    check("both_rise_no_change", 32'(bus.value_o_57), 6);
    bus.key_add_57 = 1'b0;
    bus.key_sub_57 = 1'b0;
    tick(2);

    bus.key_add_57 = 1'b1;
    tick(2);
    check("add_then_sub_first", 32'(bus.value_o_57), 7);
    bus.key_sub_57 = 1'b1;
    tick(3);
    bus.key_sub_57 = 1'b0;
    tick(6);
    check("chord_lockout", 32'(bus.value_o_57), 7);
    bus.key_add_57 = 1'b0;
    tick(2);
    press(1, 0);
    check("after_lockout_press", 32'(bus.value_o_57), 1);

    press(0, 1);
    bus.set_e_57 = 1'b0;
    bus.carry_i_57 = 1'b1;
    tick(1);
    bus.carry_i_57 = 1'b0;
    check("carry_wrap_value", 32'(bus.value_o_57), 1);
    check("carry_o_pulse", 32'(bus.carry_o_57), 1);
    tick(1);
    check("carry_o_one_cycle", 32'(bus.carry_o_57), 0);
    bus.set_e_57 = 1'b1;
    bus.carry_i_57 = 1'b1;
    tick(1);
    bus.carry_i_57 = 1'b0;
    check("carry_frozen_in_set", 32'(bus.value_o_57), 1);
    tick(1);

    bus.key_add_57 = 1'b1;
    tick(9);
    check("pre_reset_value", 32'(bus.value_o_57), 5);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_value", 32'(bus.value_o_57), 1);
    check("async_rst_rep", 32'(bus.rep_act_o_57), 0);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check("held_key_after_reset", 32'(bus.value_o_57), 1);
    bus.key_add_57 = 1'b0;
    tick(2);
    press(1, 0);
    check("repress_after_reset", 32'(bus.value_o_57), 2);

    cnt = 0;
    last = -1;
    for (int i = 0; i < 12; i++) begin
      mbus.carry_i_57 = 1'b1;
      tick(1);
      mbus.carry_i_57 = 1'b0;
      if (mbus.carry_o_57) begin
        cnt++;
        last = i;
      end
      tick(1);
    end
    check("month_carry_count", 32'(cnt), 1);
    check("month_carry_index", 32'(last), 11);
    check("month_value", 32'(mbus.value_o_57), 1);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0)  bus.key_add_57 = ~bus.key_add_57;
      if ($urandom_range(0, 5) == 0)  bus.key_sub_57 = ~bus.key_sub_57;
      if ($urandom_range(0, 39) == 0) bus.set_e_57 = ~bus.set_e_57;
      bus.carry_i_57 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0)  mbus.key_add_57 = ~mbus.key_add_57;
      if ($urandom_range(0, 5) == 0)  mbus.key_sub_57 = ~mbus.key_sub_57;
      if ($urandom_range(0, 39) == 0) mbus.set_e_57 = ~mbus.set_e_57;
      mbus.carry_i_57 = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/field_set_ctrl_57.md
Name: field_set_ctrl_57

Overview:
- Parametrised settable wrap counter for one calendar/clock field (weekday, month, hour, etc.), driven by add/sub keys during set mode and by a carry pulse from the next-lower field in run mode.
- Adds three things to the single-purpose weekday controller:
  - configurable range and reset value;
  - key auto-repeat on hold;
  - carry in/out so fields can be chained.
- Sits between the key debouncer/mode FSM and the display driver.

Parameters:
- WIDTH, 3, bit width of the field value.
- MIN_VAL, 1, lowest legal value (inclusive).
- MAX_VAL, 7, highest legal value (inclusive); must satisfy MIN_VAL < MAX_VAL < 2**WIDTH.
- RST_VAL, 1, value loaded on reset; must lie within MIN_VAL..MAX_VAL.
- HOLD_CYC, 25_000_000, cycles a key must stay high after its rising edge before auto-repeat starts (0.5 s at 50 MHz).
- REP_CYC, 5_000_000, cycles between auto-repeat steps (0.1 s at 50 MHz).

Ports:
- clk_50m_57  in  1  system clock, 50 MHz.
- rst_n_57  in  1  asynchronous active-low reset.
- set_e_57  in  1  set-mode enable for this field.
- key_add_57  in  1  debounced increment key, level, active-high.
- key_sub_57  in  1  debounced decrement key, level, active-high.
- carry_i_57  in  1  one-cycle increment pulse from the lower field.
- value_o_57  out  WIDTH  current field value.
- carry_o_57  out  1  one-cycle pulse on wrap MAX_VAL->MIN_VAL caused by carry_i_57.
- rep_act_o_57  out  1  high while auto-repeat is active (display may suppress blink).

Behaviour:
- Reset, asynchronous on rst_n_57 low:
  - value_o_57 = RST_VAL, carry_o_57 = 0, rep_act_o_57 = 0;
  - key history registers = 0, FSM = IDLE, timer = 0.
- Key history: key_add_57 and key_sub_57 are each registered once per cycle. A rising edge means current = 1 and prev = 0.
- Key FSM (only active while set_e_57 = 1):
  - IDLE:
    - add edge with key_sub_57 = 0 -> issue up-step, go to HOLD_ADD, timer = 0;
    - sub edge with key_add_57 = 0 -> issue down-step, go to HOLD_SUB, timer = 0.
  - HOLD_x:
    - timer increments each cycle while the key stays high;
    - key low -> IDLE;
    - timer reaches HOLD_CYC-1 -> issue step, go to REP_x, timer = 0.
  - REP_x:
    - rep_act_o_57 = 1;
    - timer reaches REP_CYC-1 -> issue step, timer = 0;
    - key low -> IDLE.
  - Any state: both keys high -> IDLE, no step, and no new edge accepted until both keys have been low for at least one cycle.
  - Any state: set_e_57 low -> IDLE in the next cycle, timer = 0, no step.
  - Timer width is clog2 of max(HOLD_CYC, REP_CYC).
- Steps:
  - Up-step: value == MAX_VAL -> MIN_VAL, else value + 1.
  - Down-step: value == MIN_VAL -> MAX_VAL, else value - 1.
  - value_o_57 updates on the clock edge after the cycle in which the step condition is true (1-cycle latency from the edge being sampled).
- Steps never assert carry_o_57; manual setting does not ripple into the higher field.
- Carry in:
  - With set_e_57 = 0, carry_i_57 = 1 performs an up-step.
  - If value was MAX_VAL, carry_o_57 = 1 for exactly that one cycle, registered and aligned with the value update.
  - With set_e_57 = 1, carry_i_57 is ignored (field frozen while being set).
- Out-of-range value (not reachable in normal operation): the next step or carry loads MIN_VAL.
- carry_o_57 is 0 in every cycle in which the wrap condition is not met.

Test Plan:
- Parameters WIDTH=3, MIN=1, MAX=7, RST=1, HOLD_CYC=4, REP_CYC=2.
  - Reset release, then set_e=1 and one add press -> value 1 -> 2 one cycle after the edge; carry_o stays 0.
  - Value 7, add press -> 1. Value 1, sub press -> 7. carry_o = 0 in both cases.
  - set_e=1, add held 12 cycles:
    - step at the edge;
    - step 4 cycles later, with rep_act = 1 from then on;
    - then a step every 2 cycles;
    - from 1: 2,3,4,5,6; release -> IDLE, rep_act = 0.
  - Both keys rise in the same cycle -> no change.
  - Add held, then sub also pressed -> FSM returns to IDLE with no further steps until both keys are released.
  - set_e=0, value 7, carry_i pulse -> value 1, carry_o high exactly 1 cycle.
  - set_e=1, carry_i pulse -> value unchanged, carry_o stays 0.
  - rst_n low mid-repeat (value 5):
    - value_o = 1 and rep_act = 0 immediately, without waiting for a clock edge;
    - after release, a still-held key produces no step until it is released and pressed again.
- Parameters WIDTH=4, MIN=1, MAX=12, RST=1 (month): 12 carry_i pulses from 1 -> value returns to 1 with exactly one carry_o pulse, on the 12th.
